rocket_pool_controller: RTL

Parametrised pool of rocket slots for the game layer: NUM_P player rockets and NUM_A alien rockets. Allocates a free slot on each fire request, enforces a player fire cooldown, and moves every active rocket once per frame in 1/64-pixel fixed point. Retires a rocket on collision or when it leaves the playfield. Sits between the fire/keyboard logic and the rocket draw/collision blocks, and provides the per-slot active flags and pixel positions.

---
 rtl/rocket_pool_controller.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/rocket_pool_controller.sv
// rocket_pool_controller
//   Slot pool for player and alien rockets. Each slot holds an active bit,
//   an 11-bit signed pixel X and a 17-bit signed Y with 6 fractional bits.
//   Fire requests claim the lowest free slot, a player fire cooldown is
//   counted in frames, and every active rocket moves once per frame.
//   Rockets retire on collision or when they leave the playfield rows.
//
// Ports
//   clk, resetN          clock, asynchronous active-low reset
//   startOfFrame         one-cycle frame tick (moves rockets, counts cooldown)
//   player1Fire          player fire request
//   alienFire            alien fire request, launched at alienFireX/alienFireY
//   PlayerTLX/PlayerTLY  player top-left corner, used as player launch point
//   playerHit/alienHit   per-slot collision flags
//   isActivePlayers/isActiveAliens   per-slot active flags
//   playerRocketX/Y, alienRocketX/Y  packed 11-bit signed positions, slot i at [11i+10:11i]
//   playerFired          pulse: player launch accepted
//   fireDenied           pulse: a player or alien request was dropped
module rocket_pool_controller #(
  parameter int NUM_P           = 4,
  parameter int NUM_A           = 8,
  parameter int PLAYER_SPEED    = -128,
  parameter int ALIEN_SPEED     = 96,
  parameter int MUZZLE_X_OFS    = 14,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 479
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic                      player1Fire,
  input  logic                      alienFire,
  input  logic signed [10:0]        alienFireX,
  input  logic signed [10:0]        alienFireY,
  input  logic signed [10:0]        PlayerTLX,
  input  logic signed [10:0]        PlayerTLY,
  input  logic [NUM_P-1:0]          playerHit,
  input  logic [NUM_A-1:0]          alienHit,
  output logic [NUM_P-1:0]          isActivePlayers,
  output logic [NUM_A-1:0]          isActiveAliens,
  output logic [NUM_P*11-1:0]       playerRocketX,
  output logic [NUM_P*11-1:0]       playerRocketY,
  output logic [NUM_A*11-1:0]       alienRocketX,
  output logic [NUM_A*11-1:0]       alienRocketY,
  output logic                      playerFired,
  output logic                      fireDenied
);

  localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  // Speeds are already in 1/64-pixel units; only sign extension is needed.
  localparam logic signed [16:0] P_SPD  = 17'(PLAYER_SPEED);
  localparam logic signed [16:0] A_SPD  = 17'(ALIEN_SPEED);
  localparam logic signed [10:0] MUZZLE = 11'(MUZZLE_X_OFS);
  localparam logic [CD_W-1:0]    CD_LOAD = CD_W'(COOLDOWN_FRAMES);

  // Pixel row of a fixed-point Y lies outside [Y_MIN, Y_MAX].
  function automatic logic off_screen(input logic signed [16:0] yf);
    logic signed [10:0] py;
    int                 py_i;
    py   = yf[16:6];
    py_i = int'(py);
    return (py_i < Y_MIN) || (py_i > Y_MAX);
  endfunction

  // Cooldown counts down to zero and stays there.
  function automatic logic [CD_W-1:0] sat_dec(input logic [CD_W-1:0] c);
    return (c == '0) ? c : c - CD_W'(1);
  endfunction

  // Slot state
  logic [NUM_P-1:0]        p_act;
  logic signed [10:0]      p_x  [NUM_P];
  logic signed [16:0]      p_yf [NUM_P];
  logic [NUM_A-1:0]        a_act;
  logic signed [10:0]      a_x  [NUM_A];
  logic signed [16:0]      a_yf [NUM_A];
  logic [CD_W-1:0]         cooldown;

  // Allocation and movement helpers
  logic [NUM_P-1:0]        p_sel;
  logic [NUM_A-1:0]        a_sel;
  logic                    p_found;
  logic                    a_found;
  logic                    p_launch;
  logic                    a_launch;
  logic                    p_deny;
  logic                    a_deny;
  logic signed [16:0]      p_mv [NUM_P];
  logic signed [16:0]      a_mv [NUM_A];
  logic signed [16:0]      p_ld_yf;
  logic signed [16:0]      a_ld_yf;
  logic signed [10:0]      p_ld_x;

  // Lowest-index free slot, looking only at the registered active bits so a
  // slot freed this cycle becomes allocatable one cycle later.
  always_comb begin
    p_sel   = '0;
    p_found = 1'b0;
    for (int i = 0; i < NUM_P; i++) begin
      if (!p_act[i] && !p_found) begin
        p_sel[i] = 1'b1;
        p_found  = 1'b1;
      end
    end
  end

  always_comb begin
    a_sel   = '0;
    a_found = 1'b0;
    for (int i = 0; i < NUM_A; i++) begin
      if (!a_act[i] && !a_found) begin
        a_sel[i] = 1'b1;
        a_found  = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_P; i++) p_mv[i] = p_yf[i] + P_SPD;
    for (int i = 0; i < NUM_A; i++) a_mv[i] = a_yf[i] + A_SPD;
  end

  assign p_launch = player1Fire && (cooldown == '0) && p_found;
  assign a_launch = alienFire && a_found;
  assign p_deny   = player1Fire && !p_launch;
  assign a_deny   = alienFire && !a_launch;
  assign p_ld_x   = PlayerTLX + MUZZLE;
  assign p_ld_yf  = {PlayerTLY, 6'b000000};
  assign a_ld_yf  = {alienFireY, 6'b000000};

  // Player slots. A launching slot is inactive, so hits and moves on it are
  // ignored that cycle; its first move waits for the next frame tick.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      p_act <= '0;
      for (int i = 0; i < NUM_P; i++) begin
        p_x[i]  <= '0;
        p_yf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_P; i++) begin
        if (p_launch && p_sel[i]) begin
          p_act[i] <= 1'b1;
          p_x[i]   <= p_ld_x;
          p_yf[i]  <= p_ld_yf;
        end else if (p_act[i]) begin
          // Collision wins over movement: the slot is cleared in place.
          if (playerHit[i]) begin
            p_act[i] <= 1'b0;
          end else if (startOfFrame) begin
            p_yf[i] <= p_mv[i];
            if (off_screen(p_mv[i])) p_act[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Alien slots, same rules as the player slots without a cooldown.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      a_act <= '0;
      for (int i = 0; i < NUM_A; i++) begin
        a_x[i]  <= '0;
        a_yf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_A; i++) begin
        if (a_launch && a_sel[i]) begin
          a_act[i] <= 1'b1;
          a_x[i]   <= alienFireX;
          a_yf[i]  <= a_ld_yf;
        end else if (a_act[i]) begin
          if (alienHit[i]) begin
            a_act[i] <= 1'b0;
          end else if (startOfFrame) begin
            a_yf[i] <= a_mv[i];
            if (off_screen(a_mv[i])) a_act[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Cooldown and status pulses. A launch reloads the cooldown and takes
  // precedence over a frame-tick decrement in the same cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cooldown    <= '0;
      playerFired <= 1'b0;
      fireDenied  <= 1'b0;
    end else begin
      if (p_launch)          cooldown <= CD_LOAD;
      else if (startOfFrame) cooldown <= sat_dec(cooldown);
      playerFired <= p_launch;
      fireDenied  <= p_deny || a_deny;
    end
  end

  assign isActivePlayers = p_act;
  assign isActiveAliens  = a_act;

  for (genvar g = 0; g < NUM_P; g++) begin : g_p_out
    assign playerRocketX[11*g +: 11] = p_x[g];
    assign playerRocketY[11*g +: 11] = p_yf[g][16:6];
  end

  for (genvar g = 0; g < NUM_A; g++) begin : g_a_out
    assign alienRocketX[11*g +: 11] = a_x[g];
    assign alienRocketY[11*g +: 11] = a_yf[g][16:6];
  end

endmodule
